// File: rtl/hdma_pkg.sv
// Shared types and constants for the HDMA byte-copy engine and its source decoder.
package hdma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        LATCH = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [15:0] VRAM_LO   = 16'h8000;
    localparam logic [15:0] VRAM_HI   = 16'h9FFF;
    localparam logic [15:0] ECHO_LO   = 16'hE000;
    localparam logic [7:0]  FILL_BYTE = 8'hFF;
    localparam logic [11:0] BYTES_MAX = 12'hFFF;

endpackage

// File: rtl/hdma_src_decode.sv
// Flags whether an address may be used as a DMA source: VRAM and E000h-FFFFh are not
// reachable over the external bus.
module hdma_src_decode
    import hdma_pkg::*;
(
    input  logic [15:0] addr,
    output logic        ok
);

    logic in_vram;
    logic in_high;

    assign in_vram = (addr >= VRAM_LO) && (addr <= VRAM_HI);
    assign in_high = (addr >= ECHO_LO);
    assign ok      = !(in_vram || in_high);

endmodule

// File: rtl/hdma_copy.sv
// Byte-copy engine: reads each source byte over the external bus, writes it to VRAM
// one cycle later, and stalls the CPU while a transfer is in flight.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transfer; waiting for hdma_rd
// READ  | source address on ext bus, target/validity sampled
// LATCH | source data captured; write issues in the following cycle
// FLUSH | hdma_rd dropped after a LATCH; the pending write drains
module hdma_copy
    import hdma_pkg::*;
#(
    parameter int SRC_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        hdma_rd,
    input  logic [15:0] hdma_source_addr,
    input  logic [15:0] hdma_target_addr,
    input  logic [7:0]  ext_din,
    output logic [15:0] ext_addr,
    output logic        ext_rd,
    output logic [12:0] vram_addr,
    output logic [7:0]  vram_dout,
    output logic        vram_wr,
    output logic        cpu_stall,
    output logic [11:0] burst_bytes,
    output logic        aborted
);

    if (SRC_LAT != 1) begin : g_bad_lat
        $error("hdma_copy: only SRC_LAT = 1 is supported");
    end

    state_t      state;
    logic        src_ok;
    logic        src_ok_q;
    logic [12:0] tgt_q;
    logic [7:0]  data_q;
    logic        unused_tgt_hi;

    // Target is always inside VRAM, so only the low 13 bits carry information.
    assign unused_tgt_hi = ^hdma_target_addr[15:13];

    hdma_src_decode u_src_decode (
        .addr (hdma_source_addr),
        .ok   (src_ok)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            src_ok_q    <= 1'b0;
            tgt_q       <= '0;
            data_q      <= '0;
            vram_wr     <= 1'b0;
            burst_bytes <= '0;
            aborted     <= 1'b0;
        end else begin
            vram_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (hdma_rd) begin
                        state       <= READ;
                        burst_bytes <= '0;
                        aborted     <= 1'b0;
                    end
                end
                READ: begin
                    tgt_q    <= hdma_target_addr[12:0];
                    src_ok_q <= src_ok;
                    if (hdma_rd) begin
                        state <= LATCH;
                    end else begin
                        state   <= IDLE;
                        aborted <= 1'b1;
                    end
                end
                LATCH: begin
                    data_q  <= src_ok_q ? ext_din : FILL_BYTE;
                    vram_wr <= 1'b1;
                    if (burst_bytes != BYTES_MAX) begin
                        burst_bytes <= burst_bytes + 12'd1;
                    end
                    state <= hdma_rd ? READ : FLUSH;
                end
                FLUSH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign ext_addr  = (state == READ) ? hdma_source_addr : 16'h0000;
    assign ext_rd    = (state == READ) && src_ok;
    assign vram_addr = tgt_q;
    assign vram_dout = data_q;
    assign cpu_stall = (state != IDLE) || vram_wr;

endmodule

// File: tb/tb_hdma_copy.sv
// Directed bench for hdma_copy: bursts of various lengths, invalid source, drop, reset.
module tb_hdma_copy;

    logic        clk;
    logic        reset_n;
    logic        hdma_rd;
    logic [15:0] hdma_source_addr;
    logic [15:0] hdma_target_addr;
    logic [7:0]  ext_din;
    logic [15:0] ext_addr;
    logic        ext_rd;
    logic [12:0] vram_addr;
    logic [7:0]  vram_dout;
    logic        vram_wr;
    logic        cpu_stall;
    logic [11:0] burst_bytes;
    logic        aborted;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt;
    int stall_cnt;
    int stall_last;
    int rd_cnt;

    hdma_copy #(.SRC_LAT(1)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .hdma_rd          (hdma_rd),
        .hdma_source_addr (hdma_source_addr),
        .hdma_target_addr (hdma_target_addr),
        .ext_din          (ext_din),
        .ext_addr         (ext_addr),
        .ext_rd           (ext_rd),
        .vram_addr        (vram_addr),
        .vram_dout        (vram_dout),
        .vram_wr          (vram_wr),
        .cpu_stall        (cpu_stall),
        .burst_bytes      (burst_bytes),
        .aborted          (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    function automatic logic src_valid(input logic [15:0] a);
        return !((a >= 16'h8000) && (a <= 16'h9FFF)) && (a < 16'hE000);
    endfunction

    // External memory with one cycle of read latency.
    always @(posedge clk) ext_din <= mem_byte(ext_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ext_addr"},  32'(ext_addr),    32'h0);
        chk({tag, "_ext_rd"},    32'(ext_rd),      32'h0);
        chk({tag, "_vram_addr"}, 32'(vram_addr),   32'h0);
        chk({tag, "_vram_dout"}, 32'(vram_dout),   32'h0);
        chk({tag, "_vram_wr"},   32'(vram_wr),     32'h0);
        chk({tag, "_stall"},     32'(cpu_stall),   32'h0);
        chk({tag, "_bytes"},     32'(burst_bytes), 32'h0);
        chk({tag, "_aborted"},   32'(aborted),     32'h0);
    endtask

    // Cycle k: hdma_rd high for k < nhigh; the register block advances addresses every
    // 2 cycles, lined up so that READ cycle 2i+1 sees byte i.
    task automatic burst(input logic [15:0] src, input logic [15:0] tgt,
                         input int nhigh, input int ntotal, input int rst_at);
        logic [15:0] idx;
        logic [15:0] s;
        logic [12:0] exp_a;
        logic [7:0]  exp_d;
        logic [11:0] exp_b;
        wr_cnt = 0; stall_cnt = 0; stall_last = -1; rd_cnt = 0;
        for (int k = 0; k < ntotal; k++) begin
            @(negedge clk);
            idx = (k == 0) ? 16'd0 : 16'((k - 1) / 2);
            hdma_rd          = (k < nhigh);
            hdma_source_addr = src + idx;
            hdma_target_addr = tgt + idx;
            #1;
            if (vram_wr) begin
                s     = src + 16'(wr_cnt);
                exp_a = tgt[12:0] + 13'(wr_cnt);
                exp_d = src_valid(s) ? mem_byte(s) : 8'hFF;
                exp_b = (wr_cnt >= 4095) ? 12'hFFF : 12'(wr_cnt + 1);
                chk("wr_addr", 32'(vram_addr), 32'(exp_a));
                chk("wr_data", 32'(vram_dout), 32'(exp_d));
                chk("wr_bytes", 32'(burst_bytes), 32'(exp_b));
                wr_cnt++;
            end
            if (cpu_stall) begin
                stall_cnt++;
                stall_last = k;
            end
            if (ext_rd) begin
                rd_cnt++;
                chk("ext_addr", 32'(ext_addr), 32'(src + idx));
            end
            if (k == rst_at) begin
                reset_n = 1'b0;
                hdma_rd = 1'b0;
                #1;
                check_all_zero("midrst");
                break;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        hdma_rd = 1'b0;
        hdma_source_addr = '0;
        hdma_target_addr = 16'h8000;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // GDMA 20h bytes, 64 cycles of request
        burst(16'h2040, 16'h8200, 64, 72, -1);
        chk("gdma_writes", 32'(wr_cnt), 32);
        chk("gdma_reads", 32'(rd_cnt), 32);
        chk("gdma_bytes", 32'(burst_bytes), 32'h020);
        chk("gdma_stall_cnt", 32'(stall_cnt), 65);
        chk("gdma_stall_last", 32'(stall_last), 65);
        chk("gdma_aborted", 32'(aborted), 0);

        // Three HDMA blocks with idle gaps
        for (int p = 0; p < 3; p++) begin
            burst(16'h3000 + 16'(16 * p), 16'h8400 + 16'(16 * p), 32, 50, -1);
            chk("hdma_writes", 32'(wr_cnt), 16);
            chk("hdma_bytes", 32'(burst_bytes), 32'h010);
            chk("hdma_stall_cnt", 32'(stall_cnt), 33);
            chk("hdma_aborted", 32'(aborted), 0);
        end

        // VRAM source: no external read, fill data
        burst(16'h8800, 16'h9000, 4, 10, -1);
        chk("vsrc_reads", 32'(rd_cnt), 0);
        chk("vsrc_writes", 32'(wr_cnt), 2);
        chk("vsrc_bytes", 32'(burst_bytes), 2);

        // Echo-region source also fills
        burst(16'hF000, 16'h8010, 2, 8, -1);
        chk("echo_reads", 32'(rd_cnt), 0);
        chk("echo_writes", 32'(wr_cnt), 1);

        // Odd-length request: last READ dropped
        burst(16'h1000, 16'h8000, 33, 40, -1);
        chk("odd_writes", 32'(wr_cnt), 16);
        chk("odd_bytes", 32'(burst_bytes), 16);
        chk("odd_aborted", 32'(aborted), 1);
        chk("odd_stall_cnt", 32'(stall_cnt), 33);
        chk("odd_stall_last", 32'(stall_last), 33);

        // Reset during LATCH of byte 5
        burst(16'h2100, 16'h8100, 10, 20, 10);
        chk("rst_writes", 32'(wr_cnt), 4);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rst_hold_wr", 32'(vram_wr), 0);
        end
        reset_n = 1'b1;
        burst(16'h2200, 16'h8300, 4, 10, -1);
        chk("post_rst_writes", 32'(wr_cnt), 2);
        chk("post_rst_bytes", 32'(burst_bytes), 2);

        // Long burst: counter saturates
        burst(16'h0000, 16'h8000, 8200, 8210, -1);
        chk("sat_writes", 32'(wr_cnt), 4100);
        chk("sat_bytes", 32'(burst_bytes), 32'hFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
